shift_add: RTL and testbench

- Constant-coefficient multiplier: multiplies signed fixed-point sample `data_in` by elaboration-time constant `WEIGHT`.
- `WEIGHT` is decomposed into at most `DEPTH` signed power-of-two terms, so the product is built from shifts and adds/subtracts only. No DSP multiplier is used.
- Used as the per-tap weight stage of the 2D convolution datapath; one instance per weight.
- Output is registered: 1-cycle latency, no handshake.

---
 rtl/shift_add.sv | 125 ++++++++++++
 tb/tb_shift_add.sv | 136 +++++++++++++
 2 files changed

// File: rtl/shift_add.sv
// Constant-coefficient multiplier built from signed power-of-two shift-adds; 1-cycle registered latency, no backpressure (a sample every cycle).
// Optional macro SHIFT_ADD_MULT_FALLBACK_EN: multiply fallback for weights not decomposable within DEPTH terms.
module shift_add #(
  parameter int                BITS   = 16,
  parameter int                NFRAC  = 10,
  parameter logic signed [BITS:0] WEIGHT = (BITS+1)'(1),
  parameter int                DEPTH  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [BITS-1:0]   data_in,
  output logic signed [2*BITS-1:0] data_out
);

  localparam int     PW  = BITS + NFRAC;
  localparam longint W_L = longint'(WEIGHT);

  // Nearest power of two to |r|; ties resolve to the larger exponent.
  function automatic int pick_k(input longint r);
    longint a;
    longint d;
    longint best_d;
    int     best_k;
    a      = (r < 0) ? -r : r;
    best_k = 0;
    best_d = (a > 1) ? a - 1 : 1 - a;
    for (int k = 1; k <= BITS; k++) begin
      d = a - (longint'(1) <<< k);
      if (d < 0) d = -d;
      if (d <= best_d) begin
        best_d = d;
        best_k = k;
      end
    end
    return best_k;
  endfunction

  function automatic longint residue(input int n);
    longint r;
    r = W_L;
    for (int i = 0; i < n; i++) begin
      if (r > 0)
        r = r - (longint'(1) <<< pick_k(r));
      else if (r < 0)
        r = r + (longint'(1) <<< pick_k(r));
    end
    return r;
  endfunction

  function automatic int term_sign(input int i);
    longint r;
    r = residue(i);
    return (r > 0) ? 1 : ((r < 0) ? -1 : 0);
  endfunction

  function automatic int term_k(input int i);
    return pick_k(residue(i));
  endfunction

  localparam bit DECOMP = (residue(DEPTH) == 0);

  logic signed [PW-1:0]     w_din_ext;
  logic signed [PW-1:0]     w_acc;
  logic signed [2*BITS-1:0] r_prod;
  logic                     w_unused_din;

  assign w_din_ext    = PW'(data_in);
  // A zero weight leaves the sample unconsumed by the adder tree.
  assign w_unused_din = ^data_in;

  generate
    if (DECOMP) begin : g_shift_add
      logic signed [PW-1:0] w_term [DEPTH];

      for (genvar g = 0; g < DEPTH; g++) begin : g_term
        if (term_sign(g) > 0) begin : g_pos
          assign w_term[g] = w_din_ext <<< term_k(g);
        end else if (term_sign(g) < 0) begin : g_neg
          assign w_term[g] = -(w_din_ext <<< term_k(g));
        end else begin : g_empty
          assign w_term[g] = '0;
        end
      end

      // Sum wraps modulo 2^PW by construction of the accumulator width.
      always_comb begin
        w_acc = '0;
        for (int i = 0; i < DEPTH; i++) begin
          w_acc = w_acc + w_term[i];
        end
      end
    end else begin : g_fallback
`ifdef SHIFT_ADD_MULT_FALLBACK_EN
      localparam bit FITS18 = (BITS > 18) &&
                              (W_L >= -(longint'(1) <<< 17)) &&
                              (W_L <=  (longint'(1) <<< 17) - 1);
      logic signed [PW-1:0] w_coef;

      if (FITS18) begin : g_narrow
        // Redundant sign bits dropped so the coefficient fits one 18-bit DSP port.
        localparam logic signed [17:0] W18 = 18'(W_L);
        assign w_coef = PW'(W18);
      end else begin : g_wide
        assign w_coef = PW'(WEIGHT);
      end

      assign w_acc = w_din_ext * w_coef;
`else
      $fatal(1, "shift_add: WEIGHT %0d cannot be decomposed into DEPTH %0d shift-add terms",
             W_L, DEPTH);
      assign w_acc = '0;
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_prod <= '0;
    else
      r_prod <= (2*BITS)'(w_acc);
  end

  assign data_out = r_prod;

endmodule

// File: tb/tb_shift_add.sv
// Directed checks of shift_add across several weight/width configurations sharing one clock and reset.
module tb_shift_add;

  logic clk = 1'b0;
  logic rst_n;

  logic signed [16:0] d1;
  logic signed [15:0] d2, d3, d4, d5, d6;
  logic signed [33:0] o1;
  logic signed [31:0] o2, o3, o4, o5, o6;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_add #(.BITS(17), .NFRAC(10), .WEIGHT(-18'sd5), .DEPTH(2)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(d1), .data_out(o1));
  shift_add #(.BITS(16), .NFRAC(10), .WEIGHT(17'sd3), .DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .data_in(d2), .data_out(o2));
  shift_add #(.BITS(16), .NFRAC(10), .WEIGHT(17'sd0), .DEPTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .data_in(d3), .data_out(o3));
  shift_add #(.BITS(16), .NFRAC(10), .WEIGHT(17'sd1024), .DEPTH(3)) u4 (
    .clk(clk), .rst_n(rst_n), .data_in(d4), .data_out(o4));
  // 11 = +8 +4 -1: exercises the tie-break toward the larger power.
  shift_add #(.BITS(16), .NFRAC(10), .WEIGHT(17'sd11), .DEPTH(3)) u5 (
    .clk(clk), .rst_n(rst_n), .data_in(d5), .data_out(o5));
  shift_add #(.BITS(16), .NFRAC(10), .WEIGHT(17'sh10000), .DEPTH(3)) u6 (
    .clk(clk), .rst_n(rst_n), .data_in(d6), .data_out(o6));

`ifdef SHIFT_ADD_MULT_FALLBACK_EN
  logic signed [15:0] d7;
  logic signed [31:0] o7;
  shift_add #(.BITS(16), .NFRAC(10), .WEIGHT(17'sd11), .DEPTH(2)) u7 (
    .clk(clk), .rst_n(rst_n), .data_in(d7), .data_out(o7));
`endif

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    d1 = '0; d2 = '0; d3 = '0; d4 = '0; d5 = '0; d6 = '0;
`ifdef SHIFT_ADD_MULT_FALLBACK_EN
    d7 = '0;
`endif
    #2 rst_n = 1'b0;
    #1;
    check("rst_o1", longint'(o1), 0);
    check("rst_o2", longint'(o2), 0);
    check("rst_o4", longint'(o4), 0);
    check("rst_o6", longint'(o6), 0);

    // Release between edges with the first samples already applied.
    @(negedge clk);
    d1 = 17'sd5;
    d2 = -16'sd7;
    d3 = 16'($urandom);
    d4 = 16'sh7FFF;
    d5 = -16'sd3;
    d6 = 16'sh4000;
`ifdef SHIFT_ADD_MULT_FALLBACK_EN
    d7 = -16'sd3;
`endif
    rst_n = 1'b1;
    step();
    check("w-5_c1", longint'(o1), -25);
    check("w-5_raw", longint'({30'd0, o1}), 64'sh3_FFFF_FFE7);
    check("w3_m7", longint'(o2), -21);
    check("w0_a", longint'(o3), 0);
    check("w1024_max", longint'(o4), 33553408);
    check("w11_m3", longint'(o5), -33);
    check("wrap_4000", longint'(o6), 0);
`ifdef SHIFT_ADD_MULT_FALLBACK_EN
    check("fallback_m3", longint'(o7), -33);
`endif

    d2 = 16'sd100;
    d3 = 16'($urandom);
    d4 = 16'sh8000;
    d6 = 16'sh0200;
    #1;
    check("hold_o2", longint'(o2), -21);
    check("hold_o4", longint'(o4), 33553408);
    step();
    check("w-5_c2", longint'(o1), -25);
    check("w3_100", longint'(o2), 300);
    check("w0_b", longint'(o3), 0);
    check("w1024_min", longint'(o4), -33554432);
    check("wrap_0200", longint'(o6), -33554432);

    d2 = 16'sd0;
    d3 = 16'($urandom);
    step();
    check("w-5_c3", longint'(o1), -25);
    check("w3_0", longint'(o2), 0);

    for (int i = 0; i < 4; i++) begin
      d3 = 16'($urandom);
      step();
      check("w0_rand", longint'(o3), 0);
    end

    // Reset in the middle of a clock period must clear without an edge.
    d4 = 16'sh7FFF;
    step();
    check("pre_rst_o4", longint'(o4), 33553408);
    #3 rst_n = 1'b0;
    #1;
    check("async_o4", longint'(o4), 0);
    check("async_o1", longint'(o1), 0);
    step();
    check("held_rst_o4", longint'(o4), 0);

    @(negedge clk);
    d2 = -16'sd7;
    rst_n = 1'b1;
    step();
    check("post_rst_o2", longint'(o2), -21);
    check("post_rst_o4", longint'(o4), 33553408);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
